alu_bist_ctrl: RTL and testbench
================================

Name: alu_bist_ctrl

Overview:
- Owns access to the 6-replica fault-tolerant ALU and shares it between the processor datapath and an internal built-in self-test (BIST) sequencer.
- When the processor leaves the ALU idle for IDLE_GAP consecutive cycles, the block applies one known test vector and compares every replica's raw result and zero flag against the expected value.
- Replicas that fail are permanently masked out, and an alarm is raised when too few replicas remain live for 4-of-6 voting.

Parameters:
- IDLE_GAP, 16, consecutive idle cycles (cpu_req low) required before a test starts; legal range 1..255.
- GAP_W, 8, width of the idle-gap counter.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- bist_en  in  1  enables opportunistic self-test.
- cpu_req  in  1  processor needs the ALU this cycle.
- cpu_a  in  32  processor operand A.
- cpu_b  in  32  processor operand B.
- cpu_cont  in  3  processor alucont.
- cpu_grant  out  1  processor owns the ALU this cycle.
- alu_a  out  32  operand A driven to the ALU replicas.
- alu_b  out  32  operand B driven to the ALU replicas.
- alu_cont  out  3  alucont driven to the ALU replicas.
- rep_result  in  192  raw replica results; replica i occupies bits [32i+31:32i].
- rep_zero  in  6  raw replica zero flags.
- rep_mask  out  6  live-replica mask sent to the voter; 1 = trusted.
- bist_busy  out  1  a test vector currently owns the ALU.
- test_done  out  1  one-cycle pulse after each completed check.
- fault_cnt  out  8  saturating count of failing checks.
- alarm  out  1  sticky; fewer than 4 replicas remain live.

Behaviour:
- States: IDLE, APPLY, CHECK.
- Reset values: state IDLE, gap counter 0, vec_idx 0, rep_mask 6'b111111, fault_cnt 0, alarm 0, test_done 0, bist_busy 0.
- IDLE:
  - alu_a/alu_b/alu_cont = cpu_a/cpu_b/cpu_cont, combinationally.
  - cpu_grant = cpu_req.
  - Gap counter clears when cpu_req=1 or bist_en=0; otherwise it increments, saturating at IDLE_GAP.
  - Move to APPLY when the counter equals IDLE_GAP, cpu_req=0 and bist_en=1.
  - If cpu_req rises in the cycle the threshold is reached, the processor wins: stay in IDLE and clear the counter.
- APPLY and CHECK:
  - ALU outputs = vector[vec_idx]; cpu_grant=0; bist_busy=1.
  - The test is non-preemptible, so a processor request waits at most 2 cycles.
- APPLY -> CHECK unconditionally; this cycle gives the combinational replicas settle time.
- CHECK:
  - For each i with rep_mask[i]=1: mismatch if the replica result != exp_result or rep_zero[i] != exp_zero.
  - At the clock edge: clear the rep_mask bits of mismatching replicas; if any live replica mismatched, fault_cnt += 1, saturating at 255.
  - vec_idx increments, wrapping 7->0.
  - test_done pulses in the following cycle; gap counter clears; next state IDLE.
- Masked replicas are never re-enabled except by reset; their outputs are ignored by the checker.
- alarm is set when popcount(rep_mask) < 4 after an update; sticky until reset.
- bist_en falling during APPLY or CHECK: the current vector completes; no further tests start.
- Reset mid-test: immediate return to reset values; the partially applied vector is discarded.
- Vector table (a, b, cont -> exp_result, exp_zero):
  - 0: FFFF0000, 0F0F0F0F, 000 -> 0F0F0000, 0
  - 1: 12340000, 00005678, 001 -> 12345678, 0
  - 2: 7FFFFFFF, 00000001, 010 -> 80000000, 0
  - 3: 00000005, 00000005, 110 -> 00000000, 1
  - 4: 00000003, 00000007, 111 -> 00000001, 0
  - 5: AAAAAAAA, 55555555, 001 -> FFFFFFFF, 0
  - 6: 00000000, 00000000, 000 -> 00000000, 1
  - 7: 80000000, 00000001, 111 -> 00000000, 1 (SLT is the sign of the difference, overflow ignored)

Decomposition:
- Shared package/include: state encodings, ALUCONT codes (AND=000, OR=001, ADD=010, SUB=110, SLT=111), NUM_REPLICAS=6, MIN_LIVE=4, vector-table constants.
- One sub-module, alu_bist_rom: combinational 3-bit index -> {a, b, cont, exp_result, exp_zero}.

Test Plan:
- Reset, bist_en=1, cpu_req=0, healthy replicas: APPLY at cycle 16 after reset, CHECK at 17, test_done at 18; alu_a=FFFF0000 during cycles 16-17; rep_mask stays 3F, fault_cnt 0.
- cpu_req pulses every 10 cycles with IDLE_GAP=16: no test ever starts; cpu_grant tracks cpu_req; alu outputs equal the cpu inputs.
- Force replica 2's result to 0 during vector 0: rep_mask becomes 3B, fault_cnt becomes 1, alarm stays 0; its later mismatches do not increment fault_cnt.
- Corrupt replicas 0, 1 and 3 on successive tests: final rep_mask=34, fault_cnt=3, alarm=1 after the third CHECK; alarm holds until reset.
- Raise cpu_req during APPLY: cpu_grant=0 for APPLY and CHECK, then 1 in the next cycle; the check completes normally.
- Run 9 healthy tests: vec_idx wraps 7->0 and the ninth test reapplies vector 0. Assert reset during CHECK: all outputs return to their reset values at once.

Source files
------------

// File: rtl/alu_bist_ctrl_pkg.sv
// Shared types and constants for the ALU self-test controller.
// Vector table entries hold {a, b, cont, exp_result, exp_zero}.
package alu_bist_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_APPLY = 2'd1,
      ST_CHECK = 2'd2
   } state_e;

   localparam logic [2:0] ALU_AND = 3'b000;
   localparam logic [2:0] ALU_OR  = 3'b001;
   localparam logic [2:0] ALU_ADD = 3'b010;
   localparam logic [2:0] ALU_SUB = 3'b110;
   localparam logic [2:0] ALU_SLT = 3'b111;

   localparam int NUM_REPLICAS = 6;
   localparam int MIN_LIVE     = 4;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  cont;
      logic [31:0] exp_result;
      logic        exp_zero;
   } bist_vec_t;

   localparam bist_vec_t VEC_0 =
      '{32'hFFFF0000, 32'h0F0F0F0F, ALU_AND, 32'h0F0F0000, 1'b0};
   localparam bist_vec_t VEC_1 =
      '{32'h12340000, 32'h00005678, ALU_OR,  32'h12345678, 1'b0};
   localparam bist_vec_t VEC_2 =
      '{32'h7FFFFFFF, 32'h00000001, ALU_ADD, 32'h80000000, 1'b0};
   localparam bist_vec_t VEC_3 =
      '{32'h00000005, 32'h00000005, ALU_SUB, 32'h00000000, 1'b1};
   localparam bist_vec_t VEC_4 =
      '{32'h00000003, 32'h00000007, ALU_SLT, 32'h00000001, 1'b0};
   localparam bist_vec_t VEC_5 =
      '{32'hAAAAAAAA, 32'h55555555, ALU_OR,  32'hFFFFFFFF, 1'b0};
   localparam bist_vec_t VEC_6 =
      '{32'h00000000, 32'h00000000, ALU_AND, 32'h00000000, 1'b1};
   // SLT takes the sign of the raw difference; overflow is ignored.
   localparam bist_vec_t VEC_7 =
      '{32'h80000000, 32'h00000001, ALU_SLT, 32'h00000000, 1'b1};

   function automatic logic [2:0] popcount6(
      input logic [NUM_REPLICAS-1:0] m
   );
      logic [2:0] n;
      n = '0;
      for (int i = 0; i < NUM_REPLICAS; i++) begin
         n = n + {2'b00, m[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/alu_bist_rom.sv
// Self-test vector ROM: 3-bit index to operands, opcode and
// expected result/zero flag.
module alu_bist_rom
   import alu_bist_ctrl_pkg::*;
(
   input  logic [2:0] idx_i,
   output bist_vec_t  vec_o
);

   always_comb begin
      vec_o = VEC_0;
      unique case (idx_i)
         3'd0: vec_o = VEC_0;
         3'd1: vec_o = VEC_1;
         3'd2: vec_o = VEC_2;
         3'd3: vec_o = VEC_3;
         3'd4: vec_o = VEC_4;
         3'd5: vec_o = VEC_5;
         3'd6: vec_o = VEC_6;
         3'd7: vec_o = VEC_7;
      endcase
   end

endmodule

// File: rtl/alu_bist_ctrl.sv
// Shares the 6-replica ALU between the CPU and an opportunistic
// self-test that masks failing replicas and raises a sticky alarm.
module alu_bist_ctrl
   import alu_bist_ctrl_pkg::*;
#(
   parameter int IDLE_GAP = 16,
   parameter int GAP_W    = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         bist_en,
   input  logic         cpu_req,
   input  logic [31:0]  cpu_a,
   input  logic [31:0]  cpu_b,
   input  logic [2:0]   cpu_cont,
   output logic         cpu_grant,
   output logic [31:0]  alu_a,
   output logic [31:0]  alu_b,
   output logic [2:0]   alu_cont,
   input  logic [191:0] rep_result,
   input  logic [5:0]   rep_zero,
   output logic [5:0]   rep_mask,
   output logic         bist_busy,
   output logic         test_done,
   output logic [7:0]   fault_cnt,
   output logic         alarm
);

   localparam logic [GAP_W-1:0] GAP_MAX = GAP_W'(IDLE_GAP);

   state_e           state_q, state_d;
   logic [GAP_W-1:0] gap_q, gap_d, gap_inc;
   logic [2:0]       vec_idx_q, vec_idx_d;
   logic [5:0]       mask_q, mask_d;
   logic [7:0]       fcnt_q, fcnt_d;
   logic             alarm_q, alarm_d;
   logic             done_q, done_d;
   logic [5:0]       mism;
   bist_vec_t        vec;

   alu_bist_rom u_rom (
      .idx_i (vec_idx_q),
      .vec_o (vec)
   );

   // Masked replicas never count as mismatching.
   always_comb begin
      mism = '0;
      for (int i = 0; i < NUM_REPLICAS; i++) begin
         mism[i] = mask_q[i] &
            ((rep_result[32*i +: 32] != vec.exp_result) |
             (rep_zero[i] != vec.exp_zero));
      end
   end

   assign gap_inc = (gap_q == GAP_MAX) ? gap_q : gap_q + 1'b1;

   always_comb begin
      state_d   = state_q;
      gap_d     = gap_q;
      vec_idx_d = vec_idx_q;
      mask_d    = mask_q;
      fcnt_d    = fcnt_q;
      alarm_d   = alarm_q;
      done_d    = 1'b0;
      cpu_grant = 1'b0;
      bist_busy = 1'b1;
      alu_a     = vec.a;
      alu_b     = vec.b;
      alu_cont  = vec.cont;
      unique case (state_q)
         ST_IDLE: begin
            bist_busy = 1'b0;
            cpu_grant = cpu_req;
            alu_a     = cpu_a;
            alu_b     = cpu_b;
            alu_cont  = cpu_cont;
            if (cpu_req || !bist_en) begin
               gap_d = '0;
            end else if (gap_inc == GAP_MAX) begin
               gap_d   = '0;
               state_d = ST_APPLY;
            end else begin
               gap_d = gap_inc;
            end
         end
         ST_APPLY: begin
            state_d = ST_CHECK;
         end
         ST_CHECK: begin
            mask_d = mask_q & ~mism;
            if ((|mism) && (fcnt_q != 8'hFF)) begin
               fcnt_d = fcnt_q + 8'd1;
            end
            if (popcount6(mask_d) < 3'(MIN_LIVE)) begin
               alarm_d = 1'b1;
            end
            vec_idx_d = vec_idx_q + 3'd1;
            done_d    = 1'b1;
            gap_d     = '0;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         gap_q     <= '0;
         vec_idx_q <= '0;
         mask_q    <= 6'b111111;
         fcnt_q    <= '0;
         alarm_q   <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         gap_q     <= gap_d;
         vec_idx_q <= vec_idx_d;
         mask_q    <= mask_d;
         fcnt_q    <= fcnt_d;
         alarm_q   <= alarm_d;
         done_q    <= done_d;
      end
   end

   assign rep_mask  = mask_q;
   assign fault_cnt = fcnt_q;
   assign alarm     = alarm_q;
   assign test_done = done_q;

endmodule

// File: tb/tb_alu_bist_ctrl.sv
// Bench for alu_bist_ctrl: behavioural replicas plus a
// cycle-level reference model of the self-test schedule.
module tb_alu_bist_ctrl;

   localparam int GAP = 16;

   logic         clk, reset, bist_en, cpu_req;
   logic [31:0]  cpu_a, cpu_b;
   logic [2:0]   cpu_cont;
   logic         cpu_grant;
   logic [31:0]  alu_a, alu_b;
   logic [2:0]   alu_cont;
   logic [191:0] rep_result;
   logic [5:0]   rep_zero, rep_mask;
   logic         bist_busy, test_done;
   logic [7:0]   fault_cnt;
   logic         alarm;

   logic [5:0]   corrupt;
   logic [31:0]  good;
   int           n_chk, n_fail;

   localparam logic [31:0] TV_A [8] = '{32'hFFFF0000, 32'h12340000,
      32'h7FFFFFFF, 32'h00000005, 32'h00000003, 32'hAAAAAAAA,
      32'h00000000, 32'h80000000};
   localparam logic [31:0] TV_B [8] = '{32'h0F0F0F0F, 32'h00005678,
      32'h00000001, 32'h00000005, 32'h00000007, 32'h55555555,
      32'h00000000, 32'h00000001};
   localparam logic [2:0] TV_C [8] = '{3'b000, 3'b001, 3'b010,
      3'b110, 3'b111, 3'b001, 3'b000, 3'b111};

   int         m_phase, m_run, m_vidx, m_fcnt;
   logic [5:0] m_mask;
   logic       m_alarm, m_done;

   alu_bist_ctrl #(.IDLE_GAP(GAP), .GAP_W(8)) dut (
      .clk(clk), .reset(reset), .bist_en(bist_en),
      .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_b(cpu_b),
      .cpu_cont(cpu_cont), .cpu_grant(cpu_grant),
      .alu_a(alu_a), .alu_b(alu_b), .alu_cont(alu_cont),
      .rep_result(rep_result), .rep_zero(rep_zero),
      .rep_mask(rep_mask), .bist_busy(bist_busy),
      .test_done(test_done), .fault_cnt(fault_cnt),
      .alarm(alarm)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [31:0] ref_alu(
      input logic [31:0] a, input logic [31:0] b, input logic [2:0] c
   );
      logic [31:0] d;
      d = a - b;
      case (c)
         3'b000:  return a & b;
         3'b001:  return a | b;
         3'b010:  return a + b;
         3'b110:  return d;
         3'b111:  return {31'b0, d[31]};
         default: return 32'h0;
      endcase
   endfunction

   // A corrupted replica flips bit 0 so it always disagrees.
   always_comb begin
      rep_result = '0;
      rep_zero   = '0;
      good       = ref_alu(alu_a, alu_b, alu_cont);
      for (int i = 0; i < 6; i++) begin
         rep_result[32*i +: 32] = corrupt[i] ? (good ^ 32'h1) : good;
         rep_zero[i]            = (good == 32'h0);
      end
   end

   logic [84:0] obs;
   assign obs = {cpu_grant, bist_busy, test_done, rep_mask, fault_cnt,
                 alarm, alu_a, alu_b, alu_cont};

   function automatic logic [84:0] exp_bundle();
      logic [31:0] ea, eb;
      logic [2:0]  ec;
      if (m_phase == 0) begin
         ea = cpu_a; eb = cpu_b; ec = cpu_cont;
      end else begin
         ea = TV_A[m_vidx]; eb = TV_B[m_vidx]; ec = TV_C[m_vidx];
      end
      return {(m_phase == 0) && cpu_req, m_phase != 0, m_done, m_mask,
              8'(m_fcnt), m_alarm, ea, eb, ec};
   endfunction

   task automatic model_reset();
      m_phase = 0; m_run = 0; m_vidx = 0; m_fcnt = 0;
      m_mask = 6'h3F; m_alarm = 1'b0; m_done = 1'b0;
   endtask

   // Advance one clock; the model consumes the inputs seen at the edge.
   task automatic tick();
      logic [5:0] mm;
      @(posedge clk);
      m_done = 1'b0;
      if (m_phase == 0) begin
         if (!cpu_req && bist_en && (m_run + 1 >= GAP)) begin
            m_phase = 1; m_run = 0;
         end else if (cpu_req || !bist_en) m_run = 0;
         else m_run = m_run + 1;
      end else if (m_phase == 1) begin
         m_phase = 2;
      end else begin
         mm = m_mask & corrupt;
         if (mm != 0 && m_fcnt < 255) m_fcnt = m_fcnt + 1;
         m_mask = m_mask & ~mm;
         if ($countones(m_mask) < 4) m_alarm = 1'b1;
         m_vidx = (m_vidx + 1) % 8;
         m_done = 1'b1; m_phase = 0; m_run = 0;
      end
      #1;
   endtask

   task automatic drive(input logic req, input logic en);
      cpu_req  = req;
      bist_en  = en;
      cpu_a    = $urandom;
      cpu_b    = $urandom;
      cpu_cont = 3'($urandom);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1; cpu_req = 1'b0; bist_en = 1'b0; corrupt = '0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      model_reset();
   endtask

   task automatic test_reset();
      reset = 1'b0; corrupt = '0;
      #1;
      reset = 1'b1; cpu_req = 1'b1; bist_en = 1'b1;
      cpu_a = 32'h1111_2222; cpu_b = 32'h3333_4444; cpu_cont = 3'b010;
      #1;
      n_chk++;
      if (obs !== {1'b1, 1'b0, 1'b0, 6'h3F, 8'h00, 1'b0,
                   32'h1111_2222, 32'h3333_4444, 3'b010}) begin
         n_fail++;
         $display("FAIL reset_vals: got %h want 3F/0/0 idle bundle", obs);
      end
      cpu_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      n_chk++;
      if ({bist_busy, test_done, rep_mask, fault_cnt, alarm, cpu_grant}
          !== {2'b00, 6'h3F, 8'h00, 2'b00}) begin
         n_fail++;
         $display("FAIL reset_hold: busy %b done %b mask %h",
                  bist_busy, test_done, rep_mask);
      end
      do_reset();
   endtask

   task automatic test_first_vector();
      int fb, fd;
      fb = -1; fd = -1;
      do_reset();
      for (int c = 0; c < 25; c++) begin
         drive(1'b0, 1'b1);
         n_chk++;
         if (obs !== exp_bundle()) begin
            n_fail++;
            $display("FAIL first_vec c%0d: got %h want %h", c, obs, exp_bundle());
         end
         if (bist_busy && fb < 0) fb = c;
         if (test_done && fd < 0) fd = c;
         if (c == 16 || c == 17) begin
            n_chk++;
            if (alu_a !== 32'hFFFF0000) begin
               n_fail++;
               $display("FAIL first_vec_a c%0d: got %h want FFFF0000", c, alu_a);
            end
         end
         tick();
      end
      n_chk++;
      if (fb !== 16 || fd !== 18) begin
         n_fail++;
         $display("FAIL first_timing: apply %0d done %0d want 16 18", fb, fd);
      end
      n_chk++;
      if (rep_mask !== 6'h3F || fault_cnt !== 8'h00) begin
         n_fail++;
         $display("FAIL first_health: mask %h cnt %0d want 3F 0", rep_mask, fault_cnt);
      end
   endtask

   task automatic test_cpu_pulses();
      do_reset();
      for (int c = 0; c < 80; c++) begin
         drive(c % 10 == 0, 1'b1);
         n_chk++;
         if (obs !== exp_bundle() || bist_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL cpu_pulse c%0d: got %h want %h", c, obs, exp_bundle());
         end
         tick();
      end
   endtask

   task automatic test_rep2_fault();
      int dn;
      dn = 0;
      do_reset();
      corrupt = 6'b000100;
      for (int c = 0; c < 60 && dn < 2; c++) begin
         drive(1'b0, 1'b1);
         n_chk++;
         if (obs !== exp_bundle()) begin
            n_fail++;
            $display("FAIL rep2 c%0d: got %h want %h", c, obs, exp_bundle());
         end
         if (test_done) begin
            dn++;
            n_chk++;
            if (rep_mask !== 6'h3B || fault_cnt !== 8'd1 || alarm !== 1'b0) begin
               n_fail++;
               $display("FAIL rep2_state t%0d: mask %h cnt %0d alarm %b want 3B 1 0",
                        dn, rep_mask, fault_cnt, alarm);
            end
         end
         tick();
      end
      n_chk++;
      if (dn < 2) begin
         n_fail++;
         $display("FAIL rep2_timeout: done %0d want 2", dn);
      end
   endtask

   task automatic test_multi_fault();
      logic [5:0] em [3];
      logic       ea [3];
      int         dn;
      em = '{6'h3E, 6'h3C, 6'h34};
      ea = '{1'b0, 1'b0, 1'b1};
      dn = 0;
      do_reset();
      corrupt = 6'b000001;
      for (int c = 0; c < 80 && dn < 3; c++) begin
         drive(1'b0, 1'b1);
         n_chk++;
         if (obs !== exp_bundle()) begin
            n_fail++;
            $display("FAIL multi c%0d: got %h want %h", c, obs, exp_bundle());
         end
         if (test_done) begin
            n_chk++;
            if (rep_mask !== em[dn] || fault_cnt !== 8'(dn + 1) || alarm !== ea[dn]) begin
               n_fail++;
               $display("FAIL multi_state t%0d: mask %h cnt %0d alarm %b want %h %0d %b",
                        dn, rep_mask, fault_cnt, alarm, em[dn], dn + 1, ea[dn]);
            end
            dn++;
            corrupt = (dn == 1) ? 6'b000010 : 6'b001000;
         end
         tick();
      end
      n_chk++;
      if (dn < 3) begin
         n_fail++;
         $display("FAIL multi_timeout: done %0d want 3", dn);
      end
      corrupt = '0;
      for (int c = 0; c < 40; c++) begin
         drive(1'($urandom_range(0, 3) == 0), 1'b1);
         n_chk++;
         if (obs !== exp_bundle() || alarm !== 1'b1) begin
            n_fail++;
            $display("FAIL alarm_sticky c%0d: got %h want %h", c, obs, exp_bundle());
         end
         tick();
      end
      do_reset();
      #1;
      n_chk++;
      if (alarm !== 1'b0 || rep_mask !== 6'h3F) begin
         n_fail++;
         $display("FAIL alarm_clear: alarm %b mask %h want 0 3F", alarm, rep_mask);
      end
   endtask

   task automatic test_preempt();
      int k;
      logic [2:0] eg;
      k = -1;
      eg = 3'b100;
      do_reset();
      for (int c = 0; c < 40 && k < 3; c++) begin
         if (m_phase == 1 && k < 0) k = 0;
         drive(k >= 0, 1'b1);
         n_chk++;
         if (obs !== exp_bundle()) begin
            n_fail++;
            $display("FAIL preempt c%0d: got %h want %h", c, obs, exp_bundle());
         end
         if (k >= 0) begin
            n_chk++;
            if (cpu_grant !== eg[k] || (k == 2 && test_done !== 1'b1)) begin
               n_fail++;
               $display("FAIL preempt_grant k%0d: grant %b done %b want %b",
                        k, cpu_grant, test_done, eg[k]);
            end
            k++;
         end
         tick();
      end
      n_chk++;
      if (k < 3) begin
         n_fail++;
         $display("FAIL preempt_timeout: k %0d want 3", k);
      end
   endtask

   task automatic test_wrap_and_reset();
      int na;
      logic hit;
      na = 0; hit = 1'b0;
      do_reset();
      corrupt = 6'b000001;
      for (int c = 0; c < 250 && !(na == 9 && m_phase == 2); c++) begin
         if (m_phase == 1) na++;
         drive(1'b0, 1'b1);
         n_chk++;
         if (obs !== exp_bundle()) begin
            n_fail++;
            $display("FAIL wrap c%0d: got %h want %h", c, obs, exp_bundle());
         end
         if (m_phase == 1 && na == 9) begin
            n_chk++;
            if (alu_a !== 32'hFFFF0000 || alu_cont !== 3'b000) begin
               n_fail++;
               $display("FAIL wrap_vec0: a %h cont %b want FFFF0000 000", alu_a, alu_cont);
            end
         end
         tick();
      end
      n_chk++;
      if (!(na == 9 && m_phase == 2)) begin
         n_fail++;
         $display("FAIL wrap_timeout: applies %0d want 9", na);
      end
      drive(1'b0, 1'b1);
      reset = 1'b1;
      #1;
      n_chk++;
      if (obs !== {1'b0, 1'b0, 1'b0, 6'h3F, 8'h00, 1'b0,
                   cpu_a, cpu_b, cpu_cont}) begin
         n_fail++;
         $display("FAIL reset_in_check: got %h want idle reset bundle", obs);
      end
      do_reset();
      for (int c = 0; c < 40 && !hit; c++) begin
         drive(1'b0, 1'b1);
         if (m_phase == 1) begin
            hit = 1'b1;
            n_chk++;
            if (alu_a !== 32'hFFFF0000) begin
               n_fail++;
               $display("FAIL post_reset_vec: a %h want FFFF0000", alu_a);
            end
         end
         tick();
      end
      n_chk++;
      if (!hit) begin
         n_fail++;
         $display("FAIL post_reset_timeout: no test started");
      end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 199) == 0) corrupt = 6'(1 << $urandom_range(0, 5));
         else if ($urandom_range(0, 49) == 0) corrupt = '0;
         drive($urandom_range(0, 9) == 0, $urandom_range(0, 15) != 0);
         n_chk++;
         if (obs !== exp_bundle()) begin
            n_fail++;
            $display("FAIL random c%0d: got %h want %h", c, obs, exp_bundle());
         end
         tick();
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      n_chk = 0; n_fail = 0;
      cpu_req = 1'b0; bist_en = 1'b0; corrupt = '0;
      cpu_a = '0; cpu_b = '0; cpu_cont = '0;
      model_reset();
      test_reset();
      test_first_vector();
      test_cpu_pulses();
      test_rep2_fault();
      test_multi_fault();
      test_preempt();
      test_wrap_and_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
